// File: rtl/atm_session_ctrl.sv
// ATM session controller: card detect, PIN check with try limit, menu,
// payment against a registered balance, inactivity timeout and eject.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   card_in                     card present level
//   pin_in, pin_ref, pin_enter  typed PIN, card PIN, 1-cycle entry strobe
//   bal_in                      card balance, sampled when a session starts
//   sel_opt, opt_go             menu option and its 1-cycle strobe
//   val_in                      payment amount, sampled with opt_go
//   state                       IDLE=0 PIN=1 MENU=2 PAY=3 EJECT=4
//   tempo                       cycles left before inactivity timeout
//   pin_ok                      PIN accepted in this session
//   bal_out                     current balance register
//   pay_done, pay_refused       1-cycle payment result pulses
//   eject_tries, eject_timeout  eject cause levels, held while in EJECT
module atm_session_ctrl #(
    parameter int PIN_W     = 4,
    parameter int BAL_W     = 4,
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 300
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             card_in,
    input  logic [PIN_W-1:0] pin_in,
    input  logic [PIN_W-1:0] pin_ref,
    input  logic             pin_enter,
    input  logic [BAL_W-1:0] bal_in,
    input  logic [1:0]       sel_opt,
    input  logic             opt_go,
    input  logic [BAL_W-1:0] val_in,
    output logic [2:0]       state,
    output logic [8:0]       tempo,
    output logic             pin_ok,
    output logic [BAL_W-1:0] bal_out,
    output logic             pay_done,
    output logic             pay_refused,
    output logic             eject_tries,
    output logic             eject_timeout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PIN   = 3'd1;
    localparam logic [2:0] S_MENU  = 3'd2;
    localparam logic [2:0] S_PAY   = 3'd3;
    localparam logic [2:0] S_EJECT = 3'd4;

    localparam logic [8:0] LP_TO  = 9'(TIMEOUT);
    localparam logic [2:0] LP_MAX = 3'(MAX_TRIES);

    localparam logic [1:0] OPT_SHOW = 2'd0;
    localparam logic [1:0] OPT_PAY  = 2'd1;
    localparam logic [1:0] OPT_EXIT = 2'd2;

    logic [2:0]       r_state;
    logic [8:0]       r_tempo;
    logic [2:0]       r_tries;
    logic [BAL_W-1:0] r_bal;
    logic [BAL_W-1:0] r_val;
    logic             r_pin_ok;
    logic             r_pay_done;
    logic             r_pay_ref;
    logic             r_ej_tries;
    logic             r_ej_to;

    logic [2:0]       w_state;
    logic [8:0]       w_tempo;
    logic [2:0]       w_tries;
    logic [BAL_W-1:0] w_bal;
    logic [BAL_W-1:0] w_val;
    logic             w_pin_ok;
    logic             w_pay_done;
    logic             w_pay_ref;
    logic             w_ej_tries;
    logic             w_ej_to;

    logic [8:0]       w_tempo_dec;
    logic [2:0]       w_tries_inc;
    logic             w_menu_acc;

    // Saturating countdown used on every PIN/MENU cycle that does not reload.
    assign w_tempo_dec = (r_tempo == 9'd0) ? 9'd0 : r_tempo - 9'd1;
    assign w_tries_inc = r_tries + 3'd1;
    // Option 3 is not an accepted event: it neither acts nor reloads the timer.
    assign w_menu_acc  = opt_go && (sel_opt != 2'd3);

    always_comb begin
        w_state    = r_state;
        w_tempo    = r_tempo;
        w_tries    = r_tries;
        w_bal      = r_bal;
        w_val      = r_val;
        w_pin_ok   = r_pin_ok;
        w_pay_done = 1'b0;
        w_pay_ref  = 1'b0;
        w_ej_tries = r_ej_tries;
        w_ej_to    = r_ej_to;

        case (r_state)
            S_IDLE: begin
                if (card_in) begin
                    w_state = S_PIN;
                    w_bal   = bal_in;
                    w_tries = 3'd0;
                    w_tempo = LP_TO;
                end
            end

            S_PIN: begin
                if (!card_in) begin
                    w_state    = S_IDLE;
                    w_tempo    = 9'd0;
                    w_pin_ok   = 1'b0;
                    w_ej_tries = 1'b0;
                    w_ej_to    = 1'b0;
                end else if (pin_enter) begin
                    if (pin_in == pin_ref) begin
                        w_state  = S_MENU;
                        w_pin_ok = 1'b1;
                        w_tempo  = LP_TO;
                    end else begin
                        w_tries = w_tries_inc;
                        if (w_tries_inc == LP_MAX) begin
                            w_state    = S_EJECT;
                            w_ej_tries = 1'b1;
                            w_tempo    = w_tempo_dec;
                        end else begin
                            w_tempo = LP_TO;
                        end
                    end
                end else if (r_tempo == 9'd0) begin
                    w_state = S_EJECT;
                    w_ej_to = 1'b1;
                end else begin
                    w_tempo = w_tempo_dec;
                end
            end

            S_MENU: begin
                if (!card_in) begin
                    w_state    = S_IDLE;
                    w_tempo    = 9'd0;
                    w_pin_ok   = 1'b0;
                    w_ej_tries = 1'b0;
                    w_ej_to    = 1'b0;
                end else if (w_menu_acc) begin
                    unique case (1'b1)
                        (sel_opt == OPT_SHOW): begin
                            w_tempo = LP_TO;
                        end
                        (sel_opt == OPT_PAY): begin
                            w_state = S_PAY;
                            w_val   = val_in;
                            w_tempo = w_tempo_dec;
                        end
                        (sel_opt == OPT_EXIT): begin
                            w_state = S_EJECT;
                            w_tempo = w_tempo_dec;
                        end
                        default: begin
                            w_state = r_state;
                        end
                    endcase
                end else if (r_tempo == 9'd0) begin
                    w_state = S_EJECT;
                    w_ej_to = 1'b1;
                end else begin
                    w_tempo = w_tempo_dec;
                end
            end

            S_PAY: begin
                // Card removal aborts the pending payment: no debit, no pulse.
                if (!card_in) begin
                    w_state    = S_IDLE;
                    w_tempo    = 9'd0;
                    w_pin_ok   = 1'b0;
                    w_ej_tries = 1'b0;
                    w_ej_to    = 1'b0;
                end else begin
                    if (r_val <= r_bal) begin
                        w_bal      = r_bal - r_val;
                        w_pay_done = 1'b1;
                    end else begin
                        w_pay_ref = 1'b1;
                    end
                    w_state = S_MENU;
                    w_tempo = LP_TO;
                end
            end

            S_EJECT: begin
                if (!card_in) begin
                    w_state    = S_IDLE;
                    w_tempo    = 9'd0;
                    w_pin_ok   = 1'b0;
                    w_ej_tries = 1'b0;
                    w_ej_to    = 1'b0;
                end
            end

            default: begin
                w_state    = S_IDLE;
                w_tempo    = 9'd0;
                w_pin_ok   = 1'b0;
                w_ej_tries = 1'b0;
                w_ej_to    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tempo    <= 9'd0;
            r_tries    <= 3'd0;
            r_bal      <= '0;
            r_val      <= '0;
            r_pin_ok   <= 1'b0;
            r_pay_done <= 1'b0;
            r_pay_ref  <= 1'b0;
            r_ej_tries <= 1'b0;
            r_ej_to    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_tempo    <= w_tempo;
            r_tries    <= w_tries;
            r_bal      <= w_bal;
            r_val      <= w_val;
            r_pin_ok   <= w_pin_ok;
            r_pay_done <= w_pay_done;
            r_pay_ref  <= w_pay_ref;
            r_ej_tries <= w_ej_tries;
            r_ej_to    <= w_ej_to;
        end
    end

    assign state         = r_state;
    assign tempo         = r_tempo;
    assign pin_ok        = r_pin_ok;
    assign bal_out       = r_bal;
    assign pay_done      = r_pay_done;
    assign pay_refused   = r_pay_ref;
    assign eject_tries   = r_ej_tries;
    assign eject_timeout = r_ej_to;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Testbench for atm_session_ctrl: directed vector table, timeout and
// async-reset sequences, then random traffic against a session model.
module tb_atm_session_ctrl;

    localparam int T  = 300;
    localparam int MT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       card_in = 1'b0;
    logic [3:0] pin_in = '0;
    logic [3:0] pin_ref = '0;
    logic       pin_enter = 1'b0;
    logic [3:0] bal_in = '0;
    logic [1:0] sel_opt = '0;
    logic       opt_go = 1'b0;
    logic [3:0] val_in = '0;
    logic [2:0] state;
    logic [8:0] tempo;
    logic       pin_ok;
    logic [3:0] bal_out;
    logic       pay_done;
    logic       pay_refused;
    logic       eject_tries;
    logic       eject_timeout;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    atm_session_ctrl #(
        .PIN_W(4), .BAL_W(4), .MAX_TRIES(MT), .TIMEOUT(T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .card_in(card_in),
        .pin_in(pin_in), .pin_ref(pin_ref), .pin_enter(pin_enter),
        .bal_in(bal_in), .sel_opt(sel_opt), .opt_go(opt_go),
        .val_in(val_in), .state(state), .tempo(tempo),
        .pin_ok(pin_ok), .bal_out(bal_out), .pay_done(pay_done),
        .pay_refused(pay_refused), .eject_tries(eject_tries),
        .eject_timeout(eject_timeout)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int tp,
                           input int ok, input int bal, input int pd,
                           input int pr, input int et, input int eto);
        chk({tag, ".state"}, 32'(state), st);
        chk({tag, ".tempo"}, 32'(tempo), tp);
        chk({tag, ".pin_ok"}, 32'(pin_ok), ok);
        chk({tag, ".bal_out"}, 32'(bal_out), bal);
        chk({tag, ".pay_done"}, 32'(pay_done), pd);
        chk({tag, ".pay_refused"}, 32'(pay_refused), pr);
        chk({tag, ".eject_tries"}, 32'(eject_tries), et);
        chk({tag, ".eject_timeout"}, 32'(eject_timeout), eto);
    endtask

    typedef struct {
        int card, pin, pref, pe, bal, sel, go, val;
        int st, tp, ok, b, pd, pr, et, eto;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        int card, int pin, int pref, int pe, int bal, int sel, int go,
        int val, int st, int tp, int ok, int b, int pd, int pr,
        int et, int eto);
        vec_t r;
        r = '{card, pin, pref, pe, bal, sel, go, val,
              st, tp, ok, b, pd, pr, et, eto};
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        card_in = 0; pin_enter = 0; opt_go = 0;
        pin_in = 0; pin_ref = 0; bal_in = 0; sel_opt = 0; val_in = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Session model: tracks where the customer is in the session and
    // what the machine should be showing, in plain integers.
    int m_st, m_tp, m_tries, m_bal, m_val, m_ok, m_pd, m_pr, m_et, m_eto;

    task automatic m_reset();
        m_st = 0; m_tp = 0; m_tries = 0; m_bal = 0; m_val = 0;
        m_ok = 0; m_pd = 0; m_pr = 0; m_et = 0; m_eto = 0;
    endtask

    task automatic m_end_session();
        m_st = 0; m_tp = 0; m_ok = 0; m_et = 0; m_eto = 0;
    endtask

    task automatic m_step();
        bit in_session;
        bit accepted;
        int countdown;
        in_session = (m_st == 1 || m_st == 2 || m_st == 3);
        countdown = (m_tp > 0) ? m_tp - 1 : 0;
        m_pd = 0;
        m_pr = 0;
        if (m_st == 0) begin
            if (card_in) begin
                m_st = 1; m_bal = int'(bal_in); m_tries = 0; m_tp = T;
            end
        end else if (m_st == 4) begin
            if (!card_in) m_end_session();
        end else if (in_session && !card_in) begin
            m_end_session();
        end else if (m_st == 3) begin
            if (m_val <= m_bal) begin
                m_bal = m_bal - m_val;
                m_pd = 1;
            end else begin
                m_pr = 1;
            end
            m_st = 2;
            m_tp = T;
        end else begin
            accepted = (m_st == 1) ? pin_enter : (opt_go && sel_opt != 3);
            if (!accepted) begin
                if (m_tp == 0) begin
                    m_st = 4; m_eto = 1;
                end else begin
                    m_tp = countdown;
                end
            end else if (m_st == 1) begin
                if (pin_in == pin_ref) begin
                    m_st = 2; m_ok = 1; m_tp = T;
                end else begin
                    m_tries++;
                    if (m_tries >= MT) begin
                        m_st = 4; m_et = 1; m_tp = countdown;
                    end else begin
                        m_tp = T;
                    end
                end
            end else if (sel_opt == 0) begin
                m_tp = T;
            end else if (sel_opt == 1) begin
                m_st = 3; m_val = int'(val_in); m_tp = countdown;
            end else begin
                m_st = 4; m_tp = countdown;
            end
        end
    endtask

    initial begin
        // Reset values while rst_n is held low.
        repeat (2) @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // card pin ref pe bal sel go val | st tp ok bal pd pr et eto
        tbl.push_back(v(1,0,0,0,9,0,0,0, 1,T,  0,9,0,0,0,0));
        tbl.push_back(v(1,5,5,1,0,0,0,0, 2,T,  1,9,0,0,0,0));
        tbl.push_back(v(1,0,0,0,0,1,1,4, 3,T-1,1,9,0,0,0,0));
        tbl.push_back(v(1,0,0,0,0,0,0,0, 2,T,  1,5,1,0,0,0));
        tbl.push_back(v(1,0,0,0,0,1,1,6, 3,T-1,1,5,0,0,0,0));
        tbl.push_back(v(1,0,0,0,0,0,0,0, 2,T,  1,5,0,1,0,0));
        tbl.push_back(v(1,0,0,0,0,0,0,0, 2,T-1,1,5,0,0,0,0));
        tbl.push_back(v(1,0,0,0,0,3,1,0, 2,T-2,1,5,0,0,0,0));
        tbl.push_back(v(1,0,0,0,0,0,1,0, 2,T,  1,5,0,0,0,0));
        tbl.push_back(v(1,0,0,0,0,2,1,0, 4,T-1,1,5,0,0,0,0));
        tbl.push_back(v(1,0,0,0,0,0,1,0, 4,T-1,1,5,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,  0,5,0,0,0,0));
        tbl.push_back(v(1,3,5,0,7,0,0,0, 1,T,  0,7,0,0,0,0));
        tbl.push_back(v(1,3,5,1,0,0,0,0, 1,T,  0,7,0,0,0,0));
        tbl.push_back(v(1,3,5,1,0,0,0,0, 1,T,  0,7,0,0,0,0));
        tbl.push_back(v(1,3,5,1,0,0,0,0, 4,T-1,0,7,0,0,1,0));
        tbl.push_back(v(1,5,5,1,0,0,0,0, 4,T-1,0,7,0,0,1,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,  0,7,0,0,0,0));
        tbl.push_back(v(1,0,0,0,2,0,0,0, 1,T,  0,2,0,0,0,0));
        tbl.push_back(v(1,5,5,1,0,0,0,0, 2,T,  1,2,0,0,0,0));
        tbl.push_back(v(1,0,0,0,0,1,1,2, 3,T-1,1,2,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,  0,2,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,  0,2,0,0,0,0));

        foreach (tbl[i]) begin
            @(negedge clk);
            card_in = 1'(tbl[i].card);
            pin_in = 4'(tbl[i].pin);
            pin_ref = 4'(tbl[i].pref);
            pin_enter = 1'(tbl[i].pe);
            bal_in = 4'(tbl[i].bal);
            sel_opt = 2'(tbl[i].sel);
            opt_go = 1'(tbl[i].go);
            val_in = 4'(tbl[i].val);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].tp,
                    tbl[i].ok, tbl[i].b, tbl[i].pd, tbl[i].pr,
                    tbl[i].et, tbl[i].eto);
        end

        // Inactivity timeout in PIN.
        @(negedge clk);
        pin_enter = 0; opt_go = 0; card_in = 1; bal_in = 3;
        pin_in = 5; pin_ref = 5;
        @(posedge clk); #1;
        chk("to.enter_tempo", 32'(tempo), T);
        repeat (T) @(posedge clk);
        #1;
        chk("to.tempo_zero", 32'(tempo), 0);
        chk("to.still_pin", 32'(state), 1);
        @(posedge clk); #1;
        chk_all("to.eject", 4, 0, 0, 3, 0, 0, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk_all("to.hold", 4, 0, 0, 3, 0, 0, 0, 1);
        @(negedge clk); card_in = 0;
        @(posedge clk); #1;
        chk_all("to.idle", 0, 0, 0, 3, 0, 0, 0, 0);

        // PIN entered exactly when tempo hits zero wins over timeout.
        @(negedge clk); card_in = 1;
        @(posedge clk);
        repeat (T) @(posedge clk);
        #1;
        chk("late.tempo_zero", 32'(tempo), 0);
        @(negedge clk); pin_enter = 1;
        @(posedge clk); #1;
        chk_all("late.accept", 2, T, 1, 3, 0, 0, 0, 0);
        @(negedge clk); pin_enter = 0;

        // Async reset in MENU, checked before any further clock edge.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst.state", 32'(state), 0);
        chk("arst.bal", 32'(bal_out), 0);
        chk("arst.pin_ok", 32'(pin_ok), 0);
        chk("arst.tempo", 32'(tempo), 0);

        // Random sessions against the model.
        do_reset();
        m_reset();
        pin_ref = 4'd1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            card_in   = ($urandom_range(99) < 97) ? 1'b1 : 1'b0;
            if (state == 3'd4 && $urandom_range(9) == 0) card_in = 1'b0;
            pin_in    = 4'($urandom_range(2));
            pin_enter = ($urandom_range(4) == 0);
            bal_in    = 4'($urandom_range(15));
            sel_opt   = 2'($urandom_range(3));
            opt_go    = ($urandom_range(3) == 0);
            val_in    = 4'($urandom_range(15));
            m_step();
            @(posedge clk); #1;
            chk_all("rnd", m_st, m_tp, m_ok, m_bal, m_pd, m_pr, m_et, m_eto);
            chk("rnd.pulse_excl", 32'(pay_done & pay_refused), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
